// File: rtl/bin_to_onehot_req.sv
// bin_to_onehot_req: takes a binary output-port index over a valid/ready
// handshake and holds it as a one-hot request toward the switch allocator.
// When a matching grant arrives, it reports the index and how many cycles
// the request waited.
// Optional macro BIN_TO_ONEHOT_REQ_SKID_EN adds a one-entry holding register.
// This register lets the next index queue behind an outstanding request, so
// there is no idle bubble between consecutive requests.
module bin_to_onehot_req #(
   parameter int ONEHOT_WIDTH = 16,
   parameter int BIN_WIDTH    = $clog2(ONEHOT_WIDTH),
   parameter int CNT_WIDTH    = 8
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    i_valid,
   input  logic [BIN_WIDTH-1:0]    i_bin,
   output logic                    o_ready,
   output logic [ONEHOT_WIDTH-1:0] o_req,
   input  logic [ONEHOT_WIDTH-1:0] i_grant,
   output logic                    o_done,
   output logic [BIN_WIDTH-1:0]    o_done_bin,
   output logic [CNT_WIDTH-1:0]    o_wait,
   output logic                    o_err
);

   typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

   // One extra bit so the port count itself is representable for the range check
   localparam logic [BIN_WIDTH:0]      LIMIT   = (BIN_WIDTH+1)'(ONEHOT_WIDTH);
   localparam logic [ONEHOT_WIDTH-1:0] ONE_BIT = ONEHOT_WIDTH'(1);

   state_t                  state_reg, state_next;
   logic [ONEHOT_WIDTH-1:0] req_reg, req_next;
   logic [BIN_WIDTH-1:0]    bin_reg, bin_next;
   logic [CNT_WIDTH-1:0]    cnt_reg, cnt_next;
   logic                    done_reg, done_next;
   logic [BIN_WIDTH-1:0]    done_bin_reg, done_bin_next;
   logic [CNT_WIDTH-1:0]    wait_reg, wait_next;
   logic                    err_reg, err_next;

   logic                    ready;
   logic                    accept;
   logic                    in_range;
   logic                    hit;
   logic                    load;
   logic [BIN_WIDTH-1:0]    load_bin;

`ifdef BIN_TO_ONEHOT_REQ_SKID_EN
   logic                    hold_full_reg, hold_full_next;
   logic [BIN_WIDTH-1:0]    hold_bin_reg, hold_bin_next;

   // Ready comes straight from a flop, so it never depends on valid or grant
   assign ready = !hold_full_reg;
`else
   // Without the holding register, new work is accepted only when idle
   assign ready = (state_reg == IDLE);
`endif

   assign accept   = i_valid && ready;
   assign in_range = ({1'b0, i_bin} < LIMIT);
   assign hit      = (state_reg == REQ) && (|(i_grant & req_reg));

   // State and datapath registers with asynchronous clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg     <= IDLE;
         req_reg       <= '0;
         bin_reg       <= '0;
         cnt_reg       <= '0;
         done_reg      <= 1'b0;
         done_bin_reg  <= '0;
         wait_reg      <= '0;
         err_reg       <= 1'b0;
`ifdef BIN_TO_ONEHOT_REQ_SKID_EN
         hold_full_reg <= 1'b0;
         hold_bin_reg  <= '0;
`endif
      end else begin
         state_reg     <= state_next;
         req_reg       <= req_next;
         bin_reg       <= bin_next;
         cnt_reg       <= cnt_next;
         done_reg      <= done_next;
         done_bin_reg  <= done_bin_next;
         wait_reg      <= wait_next;
         err_reg       <= err_next;
`ifdef BIN_TO_ONEHOT_REQ_SKID_EN
         hold_full_reg <= hold_full_next;
         hold_bin_reg  <= hold_bin_next;
`endif
      end
   end

   // Next-state: accept, wait-count, complete on grant hit, reload request stage
   always_comb begin
      state_next     = state_reg;
      req_next       = req_reg;
      bin_next       = bin_reg;
      cnt_next       = cnt_reg;
      done_next      = 1'b0;
      done_bin_next  = done_bin_reg;
      wait_next      = wait_reg;
      err_next       = accept && !in_range;
      load           = 1'b0;
      load_bin       = '0;
`ifdef BIN_TO_ONEHOT_REQ_SKID_EN
      hold_full_next = hold_full_reg;
      hold_bin_next  = hold_bin_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (accept && in_range) begin
               load     = 1'b1;
               load_bin = i_bin;
            end
         end
         REQ: begin
            if (hit) begin
               done_next     = 1'b1;
               done_bin_next = bin_reg;
               wait_next     = cnt_reg;
               state_next    = IDLE;
               req_next      = '0;
`ifdef BIN_TO_ONEHOT_REQ_SKID_EN
               // Queued index goes out immediately, alongside the done pulse
               if (hold_full_reg) begin
                  load           = 1'b1;
                  load_bin       = hold_bin_reg;
                  hold_full_next = 1'b0;
               end else if (accept && in_range) begin
                  load     = 1'b1;
                  load_bin = i_bin;
               end
`endif
            end else begin
               if (cnt_reg != '1) begin
                  cnt_next = cnt_reg + CNT_WIDTH'(1);
               end
`ifdef BIN_TO_ONEHOT_REQ_SKID_EN
               if (accept && in_range) begin
                  hold_full_next = 1'b1;
                  hold_bin_next  = i_bin;
               end
`endif
            end
         end
         default: begin
            state_next = IDLE;
            req_next   = '0;
         end
      endcase
      if (load) begin
         state_next = REQ;
         req_next   = ONE_BIT << load_bin;
         bin_next   = load_bin;
         cnt_next   = '0;
      end
   end

   // Outputs are driven directly from registers
   always_comb begin
      o_ready    = ready;
      o_req      = req_reg;
      o_done     = done_reg;
      o_done_bin = done_bin_reg;
      o_wait     = wait_reg;
      o_err      = err_reg;
   end

endmodule

// File: tb/tb_bin_to_onehot_req.sv
// Directed bench for bin_to_onehot_req. Instance a uses the default
// parameters. Instance b uses 12 ports with a 4-bit counter, which covers
// out-of-range indices and counter saturation.
module tb_bin_to_onehot_req;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;

   logic        a_valid;
   logic [3:0]  a_bin;
   logic        a_ready;
   logic [15:0] a_req;
   logic [15:0] a_grant;
   logic        a_done;
   logic [3:0]  a_done_bin;
   logic [7:0]  a_wait;
   logic        a_err;

   logic        b_valid;
   logic [3:0]  b_bin;
   logic        b_ready;
   logic [11:0] b_req;
   logic [11:0] b_grant;
   logic        b_done;
   logic [3:0]  b_done_bin;
   logic [3:0]  b_wait;
   logic        b_err;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   bin_to_onehot_req u_a (
      .clk(clk), .reset_n(reset_n), .i_valid(a_valid), .i_bin(a_bin),
      .o_ready(a_ready), .o_req(a_req), .i_grant(a_grant), .o_done(a_done),
      .o_done_bin(a_done_bin), .o_wait(a_wait), .o_err(a_err)
   );

   bin_to_onehot_req #(.ONEHOT_WIDTH(12), .CNT_WIDTH(4)) u_b (
      .clk(clk), .reset_n(reset_n), .i_valid(b_valid), .i_bin(b_bin),
      .o_ready(b_ready), .o_req(b_req), .i_grant(b_grant), .o_done(b_done),
      .o_done_bin(b_done_bin), .o_wait(b_wait), .o_err(b_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      a_valid = 1'b0; a_bin = '0; a_grant = '0;
      b_valid = 1'b0; b_bin = '0; b_grant = '0;

      // Reset values
      #12;
      chk("rst_ready", a_ready, 1);
      chk("rst_req", a_req, 0);
      chk("rst_done", a_done, 0);
      chk("rst_done_bin", a_done_bin, 0);
      chk("rst_wait", a_wait, 0);
      chk("rst_err", a_err, 0);
      chk("rst_b_req", b_req, 0);
      @(negedge clk);
      reset_n = 1'b1;
      step();

      // Basic: index 5, three cycles without grant, then grant
      a_valid = 1'b1; a_bin = 4'd5;
      step();
      a_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("basic_req_hold", a_req, 32'h0020);
         chk("basic_no_done", a_done, 0);
         step();
      end
      chk("basic_req_last", a_req, 32'h0020);
      a_grant = 16'h0020;
      step();
      a_grant = '0;
      chk("basic_done", a_done, 1);
      chk("basic_done_bin", a_done_bin, 5);
      chk("basic_wait", a_wait, 3);
      chk("basic_req_clear", a_req, 0);
      step();
      chk("basic_done_pulse", a_done, 0);

      // Wrong grant: grant bit 0 ignored while requesting port 2
      a_valid = 1'b1; a_bin = 4'd2;
      step();
      a_valid = 1'b0;
      a_grant = 16'h0001;
      for (int i = 0; i < 5; i++) begin
         chk("wrong_req_hold", a_req, 32'h0004);
         step();
      end
      chk("wrong_no_done", a_done, 0);
      a_grant = 16'h0004;
      step();
      a_grant = '0;
      chk("wrong_done", a_done, 1);
      chk("wrong_wait", a_wait, 5);
      chk("wrong_done_bin", a_done_bin, 2);

      // Grants while idle are ignored
      a_grant = 16'hFFFF;
      step();
      chk("idle_grant_done", a_done, 0);
      chk("idle_grant_req", a_req, 0);
      a_grant = '0;
      step();

`ifdef BIN_TO_ONEHOT_REQ_SKID_EN
      // Accept coinciding with grant hit loads directly, no bubble
      a_valid = 1'b1; a_bin = 4'd9;
      step();
      chk("b2b_req_first", a_req, 32'h0200);
      a_grant = 16'h0200; a_bin = 4'd3;
      chk("b2b_ready_in_req", a_ready, 1);
      step();
      a_valid = 1'b0;
      chk("b2b_done", a_done, 1);
      chk("b2b_done_bin", a_done_bin, 9);
      chk("b2b_req_next", a_req, 32'h0008);
      a_grant = 16'h0008;
      step();
      a_grant = '0;
      chk("b2b_done2", a_done, 1);
      chk("b2b_wait0", a_wait, 0);
      chk("b2b_done_bin2", a_done_bin, 3);
      step();

      // Skid: accept 1 then 7, grant port 1
      a_valid = 1'b1; a_bin = 4'd1;
      step();
      a_bin = 4'd7;
      chk("skid_ready_second", a_ready, 1);
      step();
      a_valid = 1'b0;
      chk("skid_ready_full", a_ready, 0);
      chk("skid_req_first", a_req, 32'h0002);
      a_grant = 16'h0002;
      step();
      a_grant = '0;
      chk("skid_done", a_done, 1);
      chk("skid_done_bin", a_done_bin, 1);
      chk("skid_req_next", a_req, 32'h0080);
      chk("skid_ready_back", a_ready, 1);
      a_grant = 16'h0080;
      step();
      a_grant = '0;
      chk("skid_done_bin2", a_done_bin, 7);
      step();
`else
      // Back-to-back: one idle bubble between grant and next request
      a_valid = 1'b1; a_bin = 4'd9;
      step();
      a_valid = 1'b0;
      chk("b2b_req_first", a_req, 32'h0200);
      a_grant = 16'h0200; a_valid = 1'b1; a_bin = 4'd3;
      chk("b2b_ready_in_req", a_ready, 0);
      step();
      chk("b2b_done", a_done, 1);
      chk("b2b_done_bin", a_done_bin, 9);
      chk("b2b_bubble_req", a_req, 0);
      chk("b2b_ready_idle", a_ready, 1);
      step();
      a_valid = 1'b0;
      chk("b2b_req_next", a_req, 32'h0008);
      a_grant = 16'h0008;
      step();
      a_grant = '0;
      chk("b2b_done2", a_done, 1);
      chk("b2b_wait0", a_wait, 0);
      chk("b2b_done_bin2", a_done_bin, 3);
      step();
`endif

      // Instance b: out-of-range index 13 and boundary index 12
      b_valid = 1'b1; b_bin = 4'd13;
      chk("oor_ready_before", b_ready, 1);
      step();
      b_valid = 1'b0;
      chk("oor_err", b_err, 1);
      chk("oor_req", b_req, 0);
      chk("oor_ready", b_ready, 1);
      step();
      chk("oor_err_pulse", b_err, 0);
      b_valid = 1'b1; b_bin = 4'd12;
      step();
      b_valid = 1'b0;
      chk("oor12_err", b_err, 1);
      chk("oor12_req", b_req, 0);
      step();

      // Instance b: highest valid index 11, grant on first cycle
      b_valid = 1'b1; b_bin = 4'd11;
      step();
      b_valid = 1'b0;
      chk("top_req", b_req, 32'h0800);
      chk("top_err", b_err, 0);
      b_grant = 12'h800;
      step();
      b_grant = '0;
      chk("top_done", b_done, 1);
      chk("top_done_bin", b_done_bin, 11);
      chk("top_wait", b_wait, 0);

      // Instance b: 20 cycles without grant saturates the 4-bit counter
      b_valid = 1'b1; b_bin = 4'd4;
      step();
      b_valid = 1'b0;
      repeat (20) step();
      chk("sat_req", b_req, 32'h0010);
      b_grant = 12'h010;
      step();
      b_grant = '0;
      chk("sat_done", b_done, 1);
      chk("sat_wait", b_wait, 15);
      step();

      // Reset mid-request clears the request without a clock edge
      a_valid = 1'b1; a_bin = 4'd8;
      step();
      a_valid = 1'b0;
      chk("mid_req", a_req, 32'h0100);
      #2;
      reset_n = 1'b0;
      #1;
      chk("mid_rst_req", a_req, 0);
      chk("mid_rst_ready", a_ready, 1);
      @(negedge clk);
      reset_n = 1'b1;
      a_grant = 16'h0100;
      step();
      chk("mid_no_done1", a_done, 0);
      step();
      chk("mid_no_done2", a_done, 0);
      chk("mid_req_after", a_req, 0);
      a_grant = '0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bin_to_onehot_req.md
# bin_to_onehot_req

Request-side counterpart of the grant decoder. Accepts a binary output-port index from a packet-header stage over a valid/ready handshake and expands it to a one-hot request vector. Holds that request toward the switch allocator until the matching one-hot grant returns, then reports completion with the index and the number of wait cycles. Sits between the input-buffer header parser and the allocator in each router input port.

## Interface
- `ONEHOT_WIDTH`, 16 — number of output ports; width of the request and grant vectors.
- `BIN_WIDTH`, `$clog2(ONEHOT_WIDTH)` — width of the binary port index.
- `CNT_WIDTH`, 8 — width of the saturating wait counter.
- `clk` in 1 — single clock; all logic is on the rising edge.
- `reset_n` in 1 — asynchronous, active-low reset.
- `i_valid` in 1 — the binary index on `i_bin` is valid.
- `i_bin` in BIN_WIDTH — requested output port index.
- `o_ready` out 1 — block can accept an index; a transfer occurs on any edge where `i_valid` and `o_ready` are both high.
- `o_req` out ONEHOT_WIDTH — registered one-hot request; all-zero when idle.
- `i_grant` in ONEHOT_WIDTH — grant vector from the allocator.
- `o_done` out 1 — one-cycle pulse indicating a request was granted.
- `o_done_bin` out BIN_WIDTH — index of the granted request; valid while `o_done` is high.
- `o_wait` out CNT_WIDTH — cycles spent waiting for the grant; valid while `o_done` is high.
- `o_err` out 1 — one-cycle pulse indicating an out-of-range index was dropped.

## Operation
- The request stage has two states, IDLE and REQ.
- **IDLE**
  - `o_req` = 0.
  - On an accept with `i_bin` < ONEHOT_WIDTH: `o_req` ← 1<<`i_bin`, the stored index ← `i_bin`, the wait counter ← 0, and the state goes to REQ.
  - On an accept with `i_bin` ≥ ONEHOT_WIDTH (possible only when ONEHOT_WIDTH is not a power of 2): the index is dropped, `o_err` pulses the next cycle, and the state stays IDLE.
- **REQ**
  - `o_req` is held constant.
  - Grant hit means (`i_grant` & `o_req`) ≠ 0.
  - On a hit edge: `o_req` ← 0, `o_done` = 1 for the next cycle, `o_done_bin` = stored index, `o_wait` = counter value, and the state goes to IDLE.
  - On a non-hit edge: the counter increments, saturating at 2^CNT_WIDTH−1.
- Grant bits outside `o_req`, and any grant while IDLE, are ignored.
- `o_wait` is the number of REQ edges without a hit. A grant on the first REQ cycle gives `o_wait` = 0.
- Reset clears all state and outputs. An outstanding request is discarded, with no `o_done`.

## Timing
- Reset values: `o_ready`=1, `o_req`=0, `o_done`=0, `o_done_bin`=0, `o_wait`=0, `o_err`=0.
- An accept at edge t drives `o_req` from t+1.
- A grant hit sampled at edge t gives `o_req`=0 and `o_done`=1 during t→t+1.
- Without the skid buffer, `o_ready` = (state==IDLE). Back-to-back requests therefore have one idle bubble: grant at t, next accept at t+1, next `o_req` at t+2.
- `o_err` is asserted during the cycle after the accept edge of the bad index.
- `o_ready` does not depend combinationally on `i_valid` or `i_grant`.

## Configuration
- `BIN_TO_ONEHOT_REQ_SKID_EN` defined:
  - Adds a one-entry holding register in front of the request stage.
  - `o_ready` = !holding_full, a registered signal.
  - An accept while IDLE loads the request stage directly. An accept while in REQ loads the holding register.
  - On a grant-hit edge with the holding register full, the request stage loads from it. That request's `o_req` is driven from t+1, concurrent with `o_done` for the previous one, with zero bubble, and the holding register empties.
  - If the holding register is empty and an accept coincides with the grant edge, the accepted index loads the request stage directly.
  - An out-of-range index is dropped at accept and never occupies the holding register.
- Macro undefined: there is no holding register, and behaviour is as described under Operation/Timing.

## Test plan
- **Basic:** reset, then accept `i_bin`=5; keep `i_grant`=0 for 3 cycles, then `i_grant`=0x0020 → `o_req`=0x0020 for 4 cycles, then `o_done`=1, `o_done_bin`=5, `o_wait`=3, `o_req`=0.
- **Wrong grant:** accept 2, drive `i_grant`=0x0001 for 5 cycles, then 0x0004 → `o_req` stays 0x0004 throughout; `o_wait`=5.
- **Out-of-range:** with ONEHOT_WIDTH=12, accept `i_bin`=13 → `o_err` pulses once, `o_req` stays 0, `o_ready` stays 1.
- **Saturation:** with CNT_WIDTH=4, hold 20 cycles without grant → `o_wait`=15 at `o_done`.
- **Reset mid-request:** `o_req`=0x0100, assert `reset_n`=0 asynchronously → `o_req`=0 immediately with no clock; no `o_done` follows.
- **Skid (macro defined):** accept 1 then 7 on consecutive cycles; grant 0x0002 → `o_done_bin`=1, with `o_req`=0x0080 in the same cycle; `o_ready` returns to 1 the cycle after.
